fifo_rd_packer: RTL and testbench

Read-domain consumer that sits directly downstream of the dual-clock async FIFO. It pops narrow words from the FIFO read port, accounting for the FIFO's one-cycle registered read latency. It packs BEATS consecutive words into one wide word and presents that word on a valid/ready output interface toward the next stage.

---
 rtl/fifo_rd_packer_if.sv | 31 +++
 rtl/fifo_rd_packer.sv | 95 +++++++++
 tb/tb_fifo_rd_packer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed-word valid/ready output
// bundled for fifo_rd_packer.
interface fifo_rd_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BEATS      = 4
);
  logic                          fifo_empty;
  logic [DATA_WIDTH-1:0]         fifo_rd_data;
  logic                          fifo_rd_en;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH*BEATS-1:0]   out_data;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en,
    output out_valid,
    input  out_ready,
    output out_data
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en,
    input  out_valid,
    output out_ready,
    input  out_data
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops narrow words from a registered-read FIFO and packs
// BEATS of them into one wide valid/ready output word.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int BEATS      = 4,
  localparam int CW        = $clog2(BEATS),
  localparam int WW        = DATA_WIDTH * BEATS
) (
  input  logic          rd_clk,
  input  logic          reset_n,
  input  logic          flush,
  output logic [CW-1:0] beat_cnt,
  fifo_rd_packer_if.master bus
);

  typedef logic [BEATS-1:0][DATA_WIDTH-1:0] asm_t;

  asm_t          asm_q, asm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          infl_q, infl_d;
  logic          held_q, held_d;
  logic          ov_q, ov_d;
  logic [WW-1:0] od_q, od_d;

  logic last;
  logic rd_en;
  logic accept;
  logic free;

  assign last   = (cnt_q == CW'(BEATS - 1));
  assign accept = ov_q && bus.out_ready;
  assign free   = !ov_q || bus.out_ready;

  // Bubble after the final-beat pop keeps one beat in flight at most.
  assign rd_en = reset_n && !bus.fifo_empty && !held_q
              && !flush && !(infl_q && last);

  always_comb begin
    asm_d  = asm_q;
    cnt_d  = cnt_q;
    infl_d = rd_en;
    held_d = held_q;
    ov_d   = ov_q;
    od_d   = od_q;
    if (accept) ov_d = 1'b0;
    if (flush) begin
      cnt_d  = '0;
      held_d = 1'b0;
    end else begin
      if (held_q && accept) begin
        od_d   = asm_q;
        ov_d   = 1'b1;
        held_d = 1'b0;
      end
      if (infl_q) begin
        asm_d[cnt_q] = bus.fifo_rd_data;
        if (last) begin
          cnt_d = '0;
          if (free) begin
            od_d = asm_d;
            ov_d = 1'b1;
          end else begin
            held_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_q  <= '0;
      cnt_q  <= '0;
      infl_q <= 1'b0;
      held_q <= 1'b0;
      ov_q   <= 1'b0;
      od_q   <= '0;
    end else begin
      asm_q  <= asm_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
      held_q <= held_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = ov_q;
  assign bus.out_data   = od_q;
  assign beat_cnt       = cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer with a queue-style
// FIFO model and a packing reference model.
module tb_fifo_rd_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] beat_cnt;

  fifo_rd_packer_if #(.DATA_WIDTH(8), .BEATS(4)) bus ();

  fifo_rd_packer #(.DATA_WIDTH(8), .BEATS(4)) dut (
    .rd_clk   (clk),
    .reset_n  (rst_n),
    .flush    (flush),
    .beat_cnt (beat_cnt),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // FIFO model with one-cycle registered read
  logic [7:0] mem [0:1023];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic stall = 1'b0;
  logic clr = 1'b0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr) || stall;

  always @(posedge clk) begin
    if (clr) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= mem[rd_ptr % 1024];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 1024] = d;
    wr_ptr++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: accepted words plus hold-stability check
  logic [31:0] rx[$];
  logic        stab_en = 1'b0;
  logic        pv = 1'b0;
  logic [31:0] pd = '0;

  always @(negedge clk) begin
    if (stab_en && pv) begin
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_data", 64'(bus.out_data), 64'(pd));
    end
    pv <= bus.out_valid && !bus.out_ready;
    pd <= bus.out_data;
    if (bus.out_valid && bus.out_ready)
      rx.push_back(bus.out_data);
  end

  task automatic wait_rx(input int n, input int lim,
                         input string nm);
    int k = 0;
    while (rx.size() < n && k < lim) begin
      step();
      k++;
    end
    chk({nm, "_count"}, 64'(rx.size()), 64'(n));
  endtask

  // Reference packing: beat b of word w is byte 4w+b of the stream
  function automatic logic [31:0] pack(input logic [7:0] s[$],
                                       input int w);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++)
      r = r | (32'(s[4*w+b]) << (8*b));
    return r;
  endfunction

  typedef struct {
    logic [7:0]  d[4];
    logic [31:0] exp;
  } vec_t;

  vec_t tv[4];

  initial begin
    logic [7:0] ws[$];
    int vmask;
    int pmask;
    int errs;
    int pushed;

    tv[0].d = '{8'h11, 8'h22, 8'h33, 8'h44};
    tv[0].exp = 32'h44332211;
    tv[1].d = '{8'h55, 8'h66, 8'h77, 8'h88};
    tv[1].exp = 32'h88776655;
    tv[2].d = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    tv[2].exp = 32'hFF00FF00;
    tv[3].d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    tv[3].exp = 32'hEFBEADDE;

    bus.out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_rden", 64'(bus.fifo_rd_en), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Latency and pop timing of a single word
    pmask = 0;
    vmask = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) pmask |= (1 << c);
      if (bus.out_valid) begin
        vmask |= (1 << c);
        chk("lat_data", 64'(bus.out_data), 64'h44332211);
      end
      step();
    end
    chk("lat_pops", 64'(pmask), 64'h0F);
    chk("lat_valid", 64'(vmask), 64'h20);

    // Table-driven packing
    foreach (tv[i]) begin
      rx.delete();
      for (int b = 0; b < 4; b++) push(tv[i].d[b]);
      wait_rx(1, 20, "tbl");
      if (rx.size() > 0)
        chk($sformatf("tbl%0d", i), 64'(rx[0]),
            64'(tv[i].exp));
    end

    // Backpressure: one word out, one held, pops stop
    rx.delete();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) push(8'(i * 8'h11));
    repeat (14) step();
    @(negedge clk);
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_data", 64'(bus.out_data), 64'h44332211);
    chk("bp_rden", 64'(bus.fifo_rd_en), 64'd0);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_w0", 64'(bus.out_data), 64'h44332211);
    step();
    @(negedge clk);
    chk("bp_w1_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_w1", 64'(bus.out_data), 64'h88776655);
    step();
    push(8'hAA); push(8'hBB); push(8'hCC);
    wait_rx(3, 30, "bp");
    if (rx.size() > 2)
      chk("bp_w2", 64'(rx[2]), 64'hCCBBAA99);

    // Empty flag toggling every cycle
    rx.delete();
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    for (int k = 0; k < 40 && rx.size() == 0; k++) begin
      stall = ~stall;
      step();
    end
    stall = 1'b0;
    chk("tog_count", 64'(rx.size()), 64'd1);
    if (rx.size() > 0)
      chk("tog_data", 64'(rx[0]), 64'hA3A2A1A0);
    chk("tog_cnt", 64'(beat_cnt), 64'd0);

    // Flush with third beat in flight
    rx.delete();
    push(8'hB0); push(8'hB1); push(8'hB2);
    step(); step(); step();
    push(8'hB3);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_cnt_pre", 64'(beat_cnt), 64'd2);
    chk("fl_rden", 64'(bus.fifo_rd_en), 64'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_cnt", 64'(beat_cnt), 64'd0);
    chk("fl_rden_after", 64'(bus.fifo_rd_en), 64'd1);
    step();
    push(8'hC0); push(8'hC1); push(8'hC2);
    wait_rx(1, 20, "fl");
    if (rx.size() > 0)
      chk("fl_data", 64'(rx[0]), 64'hC2C1C0B3);

    // Async reset mid-word with a word waiting at the output
    repeat (3) step();
    rx.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(8'hD0 + 8'(i));
    repeat (7) step();
    @(negedge clk);
    chk("ar_pre_valid", 64'(bus.out_valid), 64'd1);
    chk("ar_pre_cnt", 64'(beat_cnt), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_cnt", 64'(beat_cnt), 64'd0);
    chk("ar_rden", 64'(bus.fifo_rd_en), 64'd0);
    chk("ar_data", 64'(bus.out_data), 64'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();

    // Sustained rate: 4 pops per 5 cycles
    rx.delete();
    ws.delete();
    for (int i = 0; i < 40; i++) begin
      push(8'(i));
      ws.push_back(8'(i));
    end
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.fifo_rd_en !== ((c % 5) != 4)) errs++;
      step();
    end
    chk("tp_pattern_errs", 64'(errs), 64'd0);
    wait_rx(10, 100, "tp");
    for (int w = 0; w < 10 && w < rx.size(); w++)
      chk($sformatf("tp_w%0d", w), 64'(rx[w]),
          64'(pack(ws, w)));

    // Random stall, backpressure and arrival timing
    rx.delete();
    ws.delete();
    stab_en = 1'b1;
    pushed = 0;
    for (int k = 0; k < 3000 && pushed < 160; k++) begin
      if ($urandom_range(0, 2) != 0) begin
        ws.push_back(8'($urandom));
        push(ws[pushed]);
        pushed++;
      end
      stall = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    stall = 1'b0;
    bus.out_ready = 1'b1;
    wait_rx(40, 400, "rnd");
    step();
    stab_en = 1'b0;
    for (int w = 0; w < 40 && w < rx.size(); w++)
      chk($sformatf("rnd_w%0d", w), 64'(rx[w]),
          64'(pack(ws, w)));
    chk("rnd_end_cnt", 64'(beat_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
